// File: rtl/riscv_pkg.sv
// Shared types and constants for the RISC-V ID/EX operand stage.
package riscv_pkg;

  localparam int unsigned DATA_WIDTH    = 32;
  localparam int unsigned OPCODE_LENGTH = 4;
  localparam int unsigned REG_ADDR      = 5;

  localparam logic [OPCODE_LENGTH-1:0] ALU_AND = 4'b0000;
  localparam logic [OPCODE_LENGTH-1:0] ALU_ADD = 4'b0010;
  localparam logic [OPCODE_LENGTH-1:0] ALU_SUB = 4'b0100;
  localparam logic [OPCODE_LENGTH-1:0] ALU_EQ  = 4'b1000;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_t;

  // Everything the EX stage keeps from ID.
  typedef struct packed {
    logic                     valid;
    logic [REG_ADDR-1:0]      rs1;
    logic [REG_ADDR-1:0]      rs2;
    logic [REG_ADDR-1:0]      rd;
    logic [DATA_WIDTH-1:0]    rs1_data;
    logic [DATA_WIDTH-1:0]    rs2_data;
    logic [DATA_WIDTH-1:0]    imm;
    logic                     alu_src;
    logic [OPCODE_LENGTH-1:0] alu_op;
    logic                     reg_write;
    logic                     mem_read;
    logic                     mem_write;
    logic                     mem_to_reg;
    logic [DATA_WIDTH-1:0]    pc;
  } id_ex_t;

  function automatic logic [DATA_WIDTH-1:0] fwd_mux(
    input fwd_sel_t              sel,
    input logic [DATA_WIDTH-1:0] reg_data,
    input logic [DATA_WIDTH-1:0] mem_data,
    input logic [DATA_WIDTH-1:0] wb_data
  );
    logic [DATA_WIDTH-1:0] res;
    res = reg_data;
    case (sel)
      FWD_MEM: res = mem_data;
      FWD_WB:  res = wb_data;
      default: res = reg_data;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/forwarding_unit.sv
// Picks the freshest source for one EX operand: MEM beats WB beats the captured value.
module forwarding_unit
  import riscv_pkg::*;
(
  input  logic [REG_ADDR-1:0] rs,
  input  logic                mem_reg_write,
  input  logic [REG_ADDR-1:0] mem_rd,
  input  logic                wb_reg_write,
  input  logic [REG_ADDR-1:0] wb_rd,
  output fwd_sel_t            fwd_sel_c
);

  // x0 is hardwired zero, so a write targeting it never forwards.
  always_comb begin
    fwd_sel_c = FWD_REG;
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == rs)) begin
      fwd_sel_c = FWD_MEM;
    end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs)) begin
      fwd_sel_c = FWD_WB;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register plus EX operand forwarding, load-use bubble and flush/hold handling.
module id_ex_operand_stage
  import riscv_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     id_valid,
  input  logic [REG_ADDR-1:0]      id_rs1,
  input  logic [REG_ADDR-1:0]      id_rs2,
  input  logic [REG_ADDR-1:0]      id_rd,
  input  logic                     id_uses_rs1,
  input  logic                     id_uses_rs2,
  input  logic [DATA_WIDTH-1:0]    id_rs1_data,
  input  logic [DATA_WIDTH-1:0]    id_rs2_data,
  input  logic [DATA_WIDTH-1:0]    id_imm,
  input  logic                     id_alu_src,
  input  logic [OPCODE_LENGTH-1:0] id_alu_op,
  input  logic                     id_reg_write,
  input  logic                     id_mem_read,
  input  logic                     id_mem_write,
  input  logic                     id_mem_to_reg,
  input  logic [DATA_WIDTH-1:0]    id_pc,
  input  logic                     branch_flush,
  input  logic                     ex_hold,
  input  logic                     mem_reg_write,
  input  logic                     wb_reg_write,
  input  logic [REG_ADDR-1:0]      mem_rd,
  input  logic [REG_ADDR-1:0]      wb_rd,
  input  logic [DATA_WIDTH-1:0]    mem_result,
  input  logic [DATA_WIDTH-1:0]    wb_result,
  output logic                     id_stall,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     ex_valid,
  output logic [REG_ADDR-1:0]      ex_rd,
  output logic                     ex_reg_write,
  output logic                     ex_mem_read,
  output logic                     ex_mem_write,
  output logic                     ex_mem_to_reg,
  output logic [DATA_WIDTH-1:0]    ex_store_data,
  output logic [DATA_WIDTH-1:0]    ex_pc
);

  id_ex_t   ex_q;
  id_ex_t   id_d;
  logic     load_use_c;
  fwd_sel_t fwd_a_c;
  fwd_sel_t fwd_b_c;
  logic [DATA_WIDTH-1:0] rs1_fwd_c;
  logic [DATA_WIDTH-1:0] rs2_fwd_c;

  always_comb begin
    id_d            = '0;
    id_d.valid      = id_valid;
    id_d.rs1        = id_rs1;
    id_d.rs2        = id_rs2;
    id_d.rd         = id_rd;
    id_d.rs1_data   = id_rs1_data;
    id_d.rs2_data   = id_rs2_data;
    id_d.imm        = id_imm;
    id_d.alu_src    = id_alu_src;
    id_d.alu_op     = id_alu_op;
    id_d.reg_write  = id_reg_write;
    id_d.mem_read   = id_mem_read;
    id_d.mem_write  = id_mem_write;
    id_d.mem_to_reg = id_mem_to_reg;
    id_d.pc         = id_pc;
  end

  // A load in EX whose destination is read by the instruction in ID.
  always_comb begin
    load_use_c = 1'b0;
    if (ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) && id_valid) begin
      load_use_c = (id_uses_rs1 && (id_rs1 == ex_q.rd)) ||
                   (id_uses_rs2 && (id_rs2 == ex_q.rd));
    end
  end

  // A flush drops the dependent instruction anyway, so it must not stall the redirect.
  assign id_stall = (load_use_c && !branch_flush) || ex_hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q <= '0;
    end else if (ex_hold) begin
      ex_q <= ex_q;
    end else if (branch_flush || load_use_c) begin
      ex_q <= '0;
    end else begin
      ex_q <= id_d;
    end
  end

  forwarding_unit u_fwd_rs1 (
    .rs            (ex_q.rs1),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .fwd_sel_c     (fwd_a_c)
  );

  forwarding_unit u_fwd_rs2 (
    .rs            (ex_q.rs2),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .fwd_sel_c     (fwd_b_c)
  );

  assign rs1_fwd_c = fwd_mux(fwd_a_c, ex_q.rs1_data, mem_result, wb_result);
  assign rs2_fwd_c = fwd_mux(fwd_b_c, ex_q.rs2_data, mem_result, wb_result);

  assign SrcA          = rs1_fwd_c;
  assign SrcB          = ex_q.alu_src ? ex_q.imm : rs2_fwd_c;
  assign ex_store_data = rs2_fwd_c;
  assign Operation     = ex_q.alu_op;

  // Side-effecting controls are qualified so an empty slot can never write.
  assign ex_valid      = ex_q.valid;
  assign ex_rd         = ex_q.rd;
  assign ex_reg_write  = ex_q.valid && ex_q.reg_write;
  assign ex_mem_read   = ex_q.valid && ex_q.mem_read;
  assign ex_mem_write  = ex_q.valid && ex_q.mem_write;
  assign ex_mem_to_reg = ex_q.mem_to_reg;
  assign ex_pc         = ex_q.pc;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed plus randomized checks of id_ex_operand_stage against a behavioural model.
module tb_id_ex_operand_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_uses_rs1, id_uses_rs2;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
  logic        id_alu_src;
  logic [3:0]  id_alu_op;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        branch_flush, ex_hold;
  logic        mem_reg_write, wb_reg_write;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_result, wb_result;
  logic        id_stall;
  logic [31:0] SrcA, SrcB, ex_store_data, ex_pc;
  logic [3:0]  Operation;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic [4:0]  ex_rd;

  always #5 clk = ~clk;

  id_ex_operand_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alu_src(id_alu_src), .id_alu_op(id_alu_op),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg), .id_pc(id_pc),
    .branch_flush(branch_flush), .ex_hold(ex_hold),
    .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_result(mem_result), .wb_result(wb_result),
    .id_stall(id_stall), .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_store_data(ex_store_data), .ex_pc(ex_pc)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model of the instruction currently sitting in EX.
  bit          m_known = 0;
  bit          m_valid, m_src, m_rw, m_mr, m_mw, m_m2r;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [31:0] m_d1, m_d2, m_imm, m_pc;
  logic [3:0]  m_op;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] fwd_ref(input logic [4:0] rs, input logic [31:0] d);
    if (mem_reg_write && mem_rd != 0 && mem_rd == rs) return mem_result;
    if (wb_reg_write && wb_rd != 0 && wb_rd == rs) return wb_result;
    return d;
  endfunction

  function automatic bit load_use_ref();
    if (!(m_valid && m_mr && m_rd != 0 && id_valid)) return 0;
    return (id_uses_rs1 && id_rs1 == m_rd) || (id_uses_rs2 && id_rs2 == m_rd);
  endfunction

  task automatic check_model();
    chk("ex_valid",   32'(ex_valid),      32'(m_valid));
    chk("ex_rd",      32'(ex_rd),         32'(m_rd));
    chk("ex_rw",      32'(ex_reg_write),  32'(m_valid & m_rw));
    chk("ex_mr",      32'(ex_mem_read),   32'(m_valid & m_mr));
    chk("ex_mw",      32'(ex_mem_write),  32'(m_valid & m_mw));
    chk("ex_m2r",     32'(ex_mem_to_reg), 32'(m_m2r));
    chk("ex_pc",      ex_pc,              m_pc);
    chk("operation",  32'(Operation),     32'(m_op));
    chk("srca",       SrcA,               fwd_ref(m_rs1, m_d1));
    chk("srcb",       SrcB,               m_src ? m_imm : fwd_ref(m_rs2, m_d2));
    chk("store_data", ex_store_data,      fwd_ref(m_rs2, m_d2));
    chk("id_stall",   32'(id_stall),      32'((load_use_ref() && !branch_flush) || ex_hold));
  endtask

  task automatic model_clear();
    m_valid = 0; m_src = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_m2r = 0;
    m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_d1 = 0; m_d2 = 0; m_imm = 0; m_pc = 0; m_op = 0;
  endtask

  task automatic model_update();
    bit lu;
    lu = load_use_ref();
    if (reset) begin
      model_clear();
      m_known = 1;
    end else if (ex_hold) begin
      // contents stay
    end else if (branch_flush || lu) begin
      model_clear();
    end else begin
      m_valid = id_valid; m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
      m_d1 = id_rs1_data; m_d2 = id_rs2_data; m_imm = id_imm; m_src = id_alu_src;
      m_op = id_alu_op; m_rw = id_reg_write; m_mr = id_mem_read; m_mw = id_mem_write;
      m_m2r = id_mem_to_reg; m_pc = id_pc;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    if (m_known) check_model();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_pc = 0; id_alu_src = 0; id_alu_op = 0;
    id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
    branch_flush = 0; ex_hold = 0; mem_reg_write = 0; wb_reg_write = 0;
    mem_rd = 0; wb_rd = 0; mem_result = 0; wb_result = 0;
  endtask

  task automatic set_instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                           input logic [31:0] d1, input logic [31:0] d2, input logic [3:0] op,
                           input bit rw, input bit mr, input bit mw);
    id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_uses_rs1 = 1; id_uses_rs2 = 1; id_rs1_data = d1; id_rs2_data = d2;
    id_imm = 32'h0000_0010; id_alu_src = 0; id_alu_op = op;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_mem_to_reg = mr;
    id_pc = 32'h0000_0100;
  endtask

  task automatic rand_id();
    id_valid = 1'($urandom_range(0, 9) != 0);
    id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7));
    id_rd = 5'($urandom_range(0, 7));
    id_uses_rs1 = 1'($urandom); id_uses_rs2 = 1'($urandom);
    id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom; id_pc = $urandom;
    id_alu_src = 1'($urandom); id_alu_op = 4'($urandom);
    id_reg_write = 1'($urandom); id_mem_read = 1'($urandom_range(0, 2) == 0);
    id_mem_write = 1'($urandom); id_mem_to_reg = 1'($urandom);
  endtask

  task automatic rand_later();
    mem_reg_write = 1'($urandom); wb_reg_write = 1'($urandom);
    mem_rd = 5'($urandom_range(0, 7)); wb_rd = 5'($urandom_range(0, 7));
    mem_result = $urandom; wb_result = $urandom;
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    cycle();
    cycle();
    chk("rst_ex_valid",  32'(ex_valid),  32'h0);
    chk("rst_operation", 32'(Operation), 32'h0);
    chk("rst_id_stall",  32'(id_stall),  32'h0);
    chk("rst_srca",      SrcA,           32'h0);
    chk("rst_ex_pc",     ex_pc,          32'h0);
    reset = 0;

    // ADD x3,x1,x2 then SUB x4,x3,x1 with x3 arriving from MEM
    set_instr(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, ALU_ADD, 1, 0, 0);
    cycle();
    chk("first_load_valid", 32'(ex_valid), 32'h1);
    set_instr(5'd3, 5'd1, 5'd4, 32'd0, 32'd5, ALU_SUB, 1, 0, 0);
    cycle();
    id_valid = 0; mem_reg_write = 1; mem_rd = 5'd3; mem_result = 32'd12;
    #1;
    chk("sub_srca", SrcA, 32'd12);
    chk("sub_srcb", SrcB, 32'd5);
    chk("sub_op",   32'(Operation), 32'(4'b0100));
    cycle();

    // MEM beats WB; x0 never forwards
    set_instr(5'd6, 5'd1, 5'd7, 32'h11, 32'h22, ALU_ADD, 1, 0, 0);
    cycle();
    id_valid = 0; mem_reg_write = 1; mem_rd = 5'd6; mem_result = 32'hAA;
    wb_reg_write = 1; wb_rd = 5'd6; wb_result = 32'hBB;
    #1;
    chk("mem_over_wb", SrcA, 32'hAA);
    cycle();
    set_instr(5'd0, 5'd1, 5'd7, 32'h0, 32'h22, ALU_ADD, 1, 0, 0);
    cycle();
    id_valid = 0; mem_reg_write = 1; mem_rd = 5'd0; mem_result = 32'd9;
    wb_reg_write = 0;
    #1;
    chk("x0_no_fwd", SrcA, 32'h0);
    cycle();
    clear_inputs();

    // LW x5 then ADD x6,x5,x1: one stall, one bubble, then WB forward
    set_instr(5'd1, 5'd0, 5'd5, 32'h40, 32'h0, ALU_ADD, 1, 1, 0);
    cycle();
    set_instr(5'd5, 5'd1, 5'd6, 32'h0, 32'h3, ALU_ADD, 1, 0, 0);
    #1;
    chk("lu_stall", 32'(id_stall), 32'h1);
    cycle();
    chk("bubble_valid", 32'(ex_valid),     32'h0);
    chk("bubble_rw",    32'(ex_reg_write), 32'h0);
    chk("stall_1cyc",   32'(id_stall),     32'h0);
    cycle();
    id_valid = 0; wb_reg_write = 1; wb_rd = 5'd5; wb_result = 32'h55;
    #1;
    chk("lu_wb_fwd", SrcA, 32'h55);
    chk("lu_add_valid", 32'(ex_valid), 32'h1);
    cycle();
    clear_inputs();

    // flush of a valid store, then flush during load-use
    set_instr(5'd1, 5'd2, 5'd0, 32'h1, 32'h2, ALU_ADD, 0, 0, 1);
    branch_flush = 1;
    cycle();
    branch_flush = 0; id_valid = 0;
    #1;
    chk("flush_valid", 32'(ex_valid),     32'h0);
    chk("flush_mw",    32'(ex_mem_write), 32'h0);
    set_instr(5'd1, 5'd0, 5'd5, 32'h40, 32'h0, ALU_ADD, 1, 1, 0);
    cycle();
    set_instr(5'd5, 5'd1, 5'd6, 32'h0, 32'h3, ALU_ADD, 1, 0, 0);
    branch_flush = 1;
    #1;
    chk("flush_lu_stall", 32'(id_stall), 32'h0);
    cycle();
    chk("flush_lu_bubble", 32'(ex_valid), 32'h0);
    clear_inputs();

    // hold for three cycles while ID churns; flush on the last one must lose
    set_instr(5'd1, 5'd2, 5'd9, 32'h1, 32'h2, ALU_EQ, 1, 0, 0);
    cycle();
    ex_hold = 1;
    for (int i = 0; i < 3; i++) begin
      rand_id();
      branch_flush = (i == 2);
      #1;
      chk("hold_rd",    32'(ex_rd),     32'd9);
      chk("hold_op",    32'(Operation), 32'(ALU_EQ));
      chk("hold_pc",    ex_pc,          32'h100);
      chk("hold_stall", 32'(id_stall),  32'h1);
      cycle();
    end
    chk("hold_valid_after", 32'(ex_valid), 32'h1);
    clear_inputs();

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rand_id();
      rand_later();
      branch_flush = 1'($urandom_range(0, 9) == 0);
      ex_hold = 1'($urandom_range(0, 9) == 0);
      reset = 1'($urandom_range(0, 49) == 0);
      cycle();
    end
    reset = 0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
